nonce_result_tx: RTL and testbench

- UART transmit-side packetiser that returns mining results to the host. It is the return direction of the serial link that delivers the 640-bit block header.
- On a send request it snapshots the 32-bit nonce and the found flag, then frames them as a 7-byte packet. The packet is serialised 8N1, LSB-first, on txd.
- It sits beside the miner control and the processor, driven by the processor's time-to-send strobe on the 50 MHz UART clock domain.

---
 rtl/nonce_result_tx.sv | 195 +++++++++++++++++++
 tb/tb_nonce_result_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_tx.sv
// -----------------------------------------------------------------------------
// nonce_result_tx
//
// Purpose:
//   Serial return path for mining results. When a send request is accepted,
//   the 32-bit nonce and the found flag are snapshotted. They are then sent as
//   a 7-byte packet, 8N1 and LSB-first, on txd:
//     B0 = SYNC_BYTE
//     B1 = {7'b0, found}
//     B2..B5 = nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0]
//     B6 = B1 ^ B2 ^ B3 ^ B4 ^ B5
//   Bytes follow each other with no idle gap. Every bit lasts CLKS_PER_BIT
//   clocks.
//
// Ports:
//   clock  - UART-domain clock; all state updates on the rising edge
//   reset  - synchronous, active-low reset
//   send   - request to transmit; only sampled while busy=0
//   nonce  - nonce to report; captured on the accepting edge
//   found  - 1 = valid hash found; captured together with nonce
//   txd    - serial line; idles high
//   busy   - high from the cycle after acceptance until the packet completes
//   done   - one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module nonce_result_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] nonce,
    input  logic        found,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BYTE = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  baud_reg, baud_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [2:0]     byte_idx_reg, byte_idx_next;
    logic [31:0]    nonce_snap_reg, nonce_snap_next;
    logic           found_snap_reg, found_snap_next;
    logic           txd_reg, txd_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;

    logic           baud_last;
    logic [7:0]     pkt_bytes [0:7];

    // ------------------------------------------------------------------
    // Packet byte table, built only from the snapshot registers.
    // Entry 7 is never selected because the byte index stops at 6. It is
    // tied off so that the 3-bit index always addresses a defined entry.
    // ------------------------------------------------------------------
    assign pkt_bytes[0] = SYNC_BYTE;
    assign pkt_bytes[1] = {7'b0, found_snap_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nonce_bytes
            assign pkt_bytes[2 + gi] = nonce_snap_reg[31 - 8*gi -: 8];
        end
    endgenerate

    assign pkt_bytes[6] = {7'b0, found_snap_reg} ^ nonce_snap_reg[31:24]
                        ^ nonce_snap_reg[23:16] ^ nonce_snap_reg[15:8]
                        ^ nonce_snap_reg[7:0];
    assign pkt_bytes[7] = SYNC_BYTE;

    assign baud_last = (baud_reg == BAUD_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            baud_reg       <= '0;
            bit_idx_reg    <= '0;
            byte_idx_reg   <= '0;
            nonce_snap_reg <= '0;
            found_snap_reg <= 1'b0;
            txd_reg        <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_idx_reg    <= bit_idx_next;
            byte_idx_reg   <= byte_idx_next;
            nonce_snap_reg <= nonce_snap_next;
            found_snap_reg <= found_snap_next;
            txd_reg        <= txd_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. txd, busy and done are registered. Their next
    // values are derived from the next state, so each output changes on
    // the same edge as the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        baud_next       = baud_reg;
        bit_idx_next    = bit_idx_reg;
        byte_idx_next   = byte_idx_reg;
        nonce_snap_next = nonce_snap_reg;
        found_snap_next = found_snap_reg;
        done_next       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (send) begin
                    nonce_snap_next = nonce;
                    found_snap_next = found;
                    baud_next       = '0;
                    bit_idx_next    = '0;
                    byte_idx_next   = '0;
                    state_next      = START;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (byte_idx_reg < LAST_BYTE) begin
                        byte_idx_next = byte_idx_reg + 3'd1;
                        state_next    = START;
                    end else begin
                        byte_idx_next = '0;
                        state_next    = IDLE;
                        done_next     = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end

            default: state_next = IDLE;
        endcase

        // Line level for the cycle after this edge. In DATA the snapshot is
        // already stable, so the table built from the snapshot registers is
        // valid here.
        unique case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = pkt_bytes[byte_idx_next][bit_idx_next];
            default: txd_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign txd  = txd_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_nonce_result_tx.sv
// -----------------------------------------------------------------------------
// tb_nonce_result_tx
//
// Self-checking bench for nonce_result_tx with CLKS_PER_BIT=4.
// A monitor decodes txd into bytes and pops expected bytes from a scoreboard
// queue. The stimulus tasks fill that queue whenever a packet is requested.
// -----------------------------------------------------------------------------
module tb_nonce_result_tx;

    localparam int CPB = 4;
    localparam int PKT_CYCLES = 70 * CPB;

    logic        clk;
    logic        reset;
    logic        send;
    logic [31:0] nonce;
    logic        found;
    logic        txd;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          busy_cycles = 0;
    int          accept_cyc  = 0;
    int          done_cyc    = 0;
    logic [7:0]  exp_q [$];

    nonce_result_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clock (clk),
        .reset (reset),
        .send  (send),
        .nonce (nonce),
        .found (found),
        .txd   (txd),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard fill: expected packet bytes, derived from the packet format.
    task automatic push_pkt(input logic [31:0] n, input logic f);
        logic [7:0] b1;
        b1 = {7'b0, f};
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        exp_q.push_back(b1 ^ n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
    endtask

    // Drive a one-cycle send. accept_cyc marks the accepting edge.
    task automatic send_one(input logic [31:0] n, input logic f);
        push_pkt(n, f);
        nonce = n;
        found = f;
        send  = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        send = 1'b0;
        $display("tx request nonce=%08h found=%0d at cyc %0d", n, f, accept_cyc);
    endtask

    // Wait for a done pulse within a cycle budget. A timeout counts as a failed check.
    task automatic wait_done(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        done_cyc = cyc;
        check_val(tag, done, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Monitor: decode 8N1 from txd (sampling bit centres on negedges),
    // compare each decoded byte against the scoreboard, count busy/done,
    // and check that the line is high whenever busy=0 or done=1.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit         rx_active;
        int         rx_cnt;
        logic [7:0] rx_byte;
        logic [7:0] exp_byte;
        rx_active = 0;
        rx_cnt    = 0;
        rx_byte   = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                rx_active = 0;
                exp_q.delete();
            end else begin
                if (busy) busy_cycles++;
                if (done) done_cnt++;
                if (done || !busy) check_val("txd_idle_high", txd, 1'b1);

                if (!rx_active) begin
                    if (txd == 1'b0) begin
                        rx_active = 1;
                        rx_cnt    = 0;
                    end
                end else begin
                    rx_cnt++;
                end

                if (rx_active) begin
                    if (rx_cnt == 2) begin
                        check_val("start_bit", txd, 1'b0);
                    end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) begin
                        rx_byte[(rx_cnt - 6) / 4] = txd;
                    end else if (rx_cnt == 38) begin
                        check_val("stop_bit", txd, 1'b1);
                        check_val("rx_expected_avail", (exp_q.size() != 0), 1'b1);
                        if (exp_q.size() != 0) begin
                            exp_byte = exp_q.pop_front();
                            $display("rx byte %02h expected %02h", rx_byte, exp_byte);
                            check_val("rx_byte", rx_byte, exp_byte);
                        end
                    end
                    if (rx_cnt == 39) rx_active = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int          d0;
        int          b0;
        logic [39:0] seen;
        logic [39:0] want;
        logic [7:0]  a5;

        reset = 1'b0;
        send  = 1'b0;
        nonce = '0;
        found = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_txd", txd, 1'b1);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1) Found nonce
        d0 = done_cnt;
        b0 = busy_cycles;
        send_one(32'h42a14695, 1'b1);
        @(negedge clk);
        check_val("first_start_low", txd, 1'b0);
        wait_done("t1_done", PKT_CYCLES + 20);
        check_val("t1_done_latency", done_cyc - accept_cyc, PKT_CYCLES);
        check_val("t1_busy_after_done", busy, 1'b0);
        repeat (5) @(negedge clk);
        check_val("t1_busy_cycles", busy_cycles - b0, PKT_CYCLES);
        check_val("t1_done_count", done_cnt - d0, 1);
        check_val("t1_txd_idle", txd, 1'b1);
        check_val("t1_queue_empty", exp_q.size(), 0);

        // 2) No result, plus bit-level check of the first byte
        send_one(32'h0, 1'b0);
        a5 = 8'hA5;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen[i] = txd;
            if (i < CPB)              want[i] = 1'b0;
            else if (i < 9 * CPB)     want[i] = a5[(i / CPB) - 1];
            else                      want[i] = 1'b1;
        end
        check_val("t2_bitlevel_a5", seen, want);
        wait_done("t2_done", PKT_CYCLES);
        repeat (5) @(negedge clk);
        check_val("t2_queue_empty", exp_q.size(), 0);

        // 3) Input changes after acceptance, plus a send while busy
        @(posedge clk);
        #1;
        d0 = done_cnt;
        send_one(32'hDEADBEEF, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        nonce = 32'h0;
        found = 1'b0;
        repeat (90) @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
        wait_done("t3_done", PKT_CYCLES);
        check_val("t3_done_latency", done_cyc - accept_cyc, PKT_CYCLES);
        repeat (300) @(negedge clk);
        check_val("t3_single_done", done_cnt - d0, 1);
        check_val("t3_no_second_pkt", busy, 1'b0);
        check_val("t3_queue_empty", exp_q.size(), 0);

        // 4) Back-to-back with send held high. The second request is taken
        //    in the done cycle, so the second done comes 70*CPB+1 edges
        //    after the first one.
        d0 = done_cnt;
        b0 = busy_cycles;
        push_pkt(32'h00000001, 1'b1);
        push_pkt(32'h00000002, 1'b1);
        nonce = 32'h00000001;
        found = 1'b1;
        send  = 1'b1;
        @(posedge clk);
        #1 accept_cyc = cyc;
        $display("tx request nonce=%08h found=1 held at cyc %0d", nonce, accept_cyc);
        repeat (9) @(posedge clk);
        #1 nonce = 32'h00000002;
        wait_done("t4_done1", PKT_CYCLES);
        check_val("t4_done1_latency", done_cyc - accept_cyc, PKT_CYCLES);
        @(posedge clk);
        #1 send = 1'b0;
        check_val("t4_busy_reaccept", busy, 1'b1);
        @(negedge clk);
        check_val("t4_start2_low", txd, 1'b0);
        wait_done("t4_done2", PKT_CYCLES + 5);
        check_val("t4_done2_latency", done_cyc - accept_cyc, 2 * PKT_CYCLES + 1);
        repeat (5) @(negedge clk);
        check_val("t4_done_count", done_cnt - d0, 2);
        check_val("t4_busy_cycles", busy_cycles - b0, 2 * PKT_CYCLES);
        check_val("t4_queue_empty", exp_q.size(), 0);

        // 5) Reset mid-packet
        d0 = done_cnt;
        send_one(32'h12345678, 1'b1);
        repeat (49) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("t5_reset_txd", txd, 1'b1);
        check_val("t5_reset_busy", busy, 1'b0);
        repeat (PKT_CYCLES) @(negedge clk);
        check_val("t5_no_done", done_cnt - d0, 0);
        @(posedge clk);
        #1;
        send_one(32'h0BADF00D, 1'b0);
        wait_done("t5_done", PKT_CYCLES + 5);
        check_val("t5_done_latency", done_cyc - accept_cyc, PKT_CYCLES);
        repeat (5) @(negedge clk);
        check_val("t5_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
